// File: rtl/conv_seq_ctrl.sv
// Runtime-configurable convolution sequencer: filters -> input channels -> padded rows -> padded columns.
// Job geometry is latched at start; stall freezes sequencing and abort cancels the job.
module conv_seq_ctrl #(
  parameter int MAX_IFM = 64,
  parameter int MAX_K   = 7,
  parameter int MAX_PAD = 3,
  parameter int MAX_CI  = 512,
  parameter int MAX_CO  = 512,
  parameter int CW      = $clog2(MAX_IFM + 2*MAX_PAD + 1)
) (
  input  logic                             clk1,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             abort,
  input  logic                             stall,
  input  logic [CW-1:0]                    cfg_ifm,
  input  logic [$clog2(MAX_K+1)-1:0]       cfg_k,
  input  logic [$clog2(MAX_PAD+1)-1:0]     cfg_pad,
  input  logic [2:0]                       cfg_stride,
  input  logic [$clog2(MAX_CI+1)-1:0]      cfg_ci,
  input  logic [$clog2(MAX_CO+1)-1:0]      cfg_co,
  output logic                             busy,
  output logic                             done,
  output logic                             cfg_err,
  output logic                             wgt_read,
  output logic [$clog2(MAX_K*MAX_K)-1:0]   wgt_idx,
  output logic                             ifm_read,
  output logic                             pad_zero,
  output logic [CW-1:0]                    addr_x,
  output logic [CW-1:0]                    addr_y,
  output logic [$clog2(MAX_CI)-1:0]        addr_ci,
  output logic [$clog2(MAX_CO)-1:0]        addr_co,
  output logic                             first_ch,
  output logic                             win_valid,
  output logic                             out_valid,
  output logic [CW-1:0]                    out_x,
  output logic [CW-1:0]                    out_y
);

  localparam int KW  = $clog2(MAX_K + 1);
  localparam int PW  = $clog2(MAX_PAD + 1);
  localparam int CIW = $clog2(MAX_CI + 1);
  localparam int COW = $clog2(MAX_CO + 1);
  localparam int WIW = $clog2(MAX_K * MAX_K);
  localparam int ACW = $clog2(MAX_CI);
  localparam int AOW = $clog2(MAX_CO);
  localparam int XW  = CW + 1;

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, FIN} state_t;

  state_t         state_q;
  logic [CW-1:0]  n_q;
  logic [KW-1:0]  k_q;
  logic [PW-1:0]  p_q;
  logic [2:0]     s_q;
  logic [CIW-1:0] ci_n_q, ci_q;
  logic [COW-1:0] co_n_q, co_q;
  logic [XW-1:0]  pd_q, o_q, kk_last_q;
  logic [WIW-1:0] wi_q;
  logic [XW-1:0]  row_q, col_q, rq_q, cq_q;
  logic [2:0]     rph_q, cph_q;
  logic           err_q;

  logic [XW-1:0]  pd_in, kk_in, diff_in, o_in;
  logic           cfg_bad;

  // Candidate geometry for the job being requested; O needs only a constant-divisor divide.
  always_comb begin
    pd_in   = XW'(cfg_ifm) + (XW'(cfg_pad) << 1);
    kk_in   = XW'(cfg_k) * XW'(cfg_k);
    diff_in = pd_in - XW'(cfg_k);
    case (cfg_stride)
      3'd1:    o_in = diff_in;
      3'd2:    o_in = diff_in >> 1;
      3'd3:    o_in = diff_in / XW'(3);
      default: o_in = diff_in >> 2;
    endcase
    o_in    = o_in + XW'(1);
    cfg_bad = (cfg_k == '0) || (cfg_stride == 3'd0) || (cfg_stride > 3'd4) ||
              (cfg_ifm == '0) || (cfg_ci == '0) || (cfg_co == '0) || (XW'(cfg_k) > pd_in);
  end

  logic [XW-1:0] km1, rq_d, cq_d;
  logic [2:0]    s_m1, rph_d, cph_d;
  logic          col_last, row_last, ch_last, co_last, kk_done;

  // Stride phase/quotient counters only start moving once a full kernel span has been covered.
  always_comb begin
    km1      = XW'(k_q) - XW'(1);
    s_m1     = s_q - 3'd1;
    col_last = (col_q == pd_q - XW'(1));
    row_last = (row_q == pd_q - XW'(1));
    ch_last  = (ci_q == ci_n_q - CIW'(1));
    co_last  = (co_q == co_n_q - COW'(1));
    kk_done  = (XW'(wi_q) == kk_last_q);
    cph_d    = cph_q;
    cq_d     = cq_q;
    rph_d    = rph_q;
    rq_d     = rq_q;
    if (col_q >= km1) begin
      if (cph_q == s_m1) begin
        cph_d = 3'd0;
        cq_d  = cq_q + XW'(1);
      end else begin
        cph_d = cph_q + 3'd1;
      end
    end
    if (row_q >= km1) begin
      if (rph_q == s_m1) begin
        rph_d = 3'd0;
        rq_d  = rq_q + XW'(1);
      end else begin
        rph_d = rph_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      n_q       <= '0;
      k_q       <= '0;
      p_q       <= '0;
      s_q       <= '0;
      ci_n_q    <= '0;
      co_n_q    <= '0;
      pd_q      <= '0;
      o_q       <= '0;
      kk_last_q <= '0;
      wi_q      <= '0;
      row_q     <= '0;
      col_q     <= '0;
      rq_q      <= '0;
      cq_q      <= '0;
      rph_q     <= '0;
      cph_q     <= '0;
      ci_q      <= '0;
      co_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (cfg_bad) begin
              err_q <= 1'b1;
            end else begin
              n_q       <= cfg_ifm;
              k_q       <= cfg_k;
              p_q       <= cfg_pad;
              s_q       <= cfg_stride;
              ci_n_q    <= cfg_ci;
              co_n_q    <= cfg_co;
              pd_q      <= pd_in;
              o_q       <= o_in;
              kk_last_q <= kk_in - XW'(1);
              state_q   <= LOAD;
            end
          end
        end
        LOAD, STREAM: begin
          if (abort) begin
            wi_q    <= '0;
            row_q   <= '0;
            col_q   <= '0;
            rq_q    <= '0;
            cq_q    <= '0;
            rph_q   <= '0;
            cph_q   <= '0;
            ci_q    <= '0;
            co_q    <= '0;
            state_q <= IDLE;
          end else if (!stall) begin
            if (state_q == LOAD) begin
              if (kk_done) begin
                wi_q    <= '0;
                state_q <= STREAM;
              end else begin
                wi_q <= wi_q + WIW'(1);
              end
            end else if (!col_last) begin
              col_q <= col_q + XW'(1);
              cph_q <= cph_d;
              cq_q  <= cq_d;
            end else begin
              col_q <= '0;
              cph_q <= '0;
              cq_q  <= '0;
              if (!row_last) begin
                row_q <= row_q + XW'(1);
                rph_q <= rph_d;
                rq_q  <= rq_d;
              end else begin
                row_q <= '0;
                rph_q <= '0;
                rq_q  <= '0;
                if (!ch_last) begin
                  ci_q    <= ci_q + CIW'(1);
                  state_q <= LOAD;
                end else if (!co_last) begin
                  ci_q    <= '0;
                  co_q    <= co_q + COW'(1);
                  state_q <= LOAD;
                end else begin
                  ci_q    <= '0;
                  co_q    <= '0;
                  state_q <= FIN;
                end
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic          streaming, live, pad_pos, win_pos;
  logic [XW-1:0] p_lo, p_hi;

  // Position decode is Moore from the counters; stall only masks the strobes.
  always_comb begin
    streaming = (state_q == STREAM);
    live      = streaming && !stall;
    p_lo      = XW'(p_q);
    p_hi      = XW'(p_q) + XW'(n_q);
    pad_pos   = (row_q < p_lo) || (row_q >= p_hi) || (col_q < p_lo) || (col_q >= p_hi);
    win_pos   = (row_q >= km1) && (col_q >= km1) && (rph_q == 3'd0) && (cph_q == 3'd0) &&
                (rq_q < o_q) && (cq_q < o_q);
  end

  assign busy      = (state_q == LOAD) || (state_q == STREAM);
  assign done      = (state_q == FIN);
  assign cfg_err   = err_q;
  assign wgt_read  = (state_q == LOAD) && !stall;
  assign wgt_idx   = wi_q;
  assign ifm_read  = live && !pad_pos;
  assign pad_zero  = live && pad_pos;
  assign addr_x    = streaming ? CW'(col_q - p_lo) : '0;
  assign addr_y    = streaming ? CW'(row_q - p_lo) : '0;
  assign addr_ci   = ACW'(ci_q);
  assign addr_co   = AOW'(co_q);
  assign first_ch  = busy && (ci_q == '0);
  assign win_valid = live && win_pos;
  assign out_valid = win_valid && ch_last;
  assign out_x     = streaming ? CW'(cq_q) : '0;
  assign out_y     = streaming ? CW'(rq_q) : '0;

endmodule

// File: doc/conv_seq_ctrl.md
Name: conv_seq_ctrl

Overview:
- Runtime-configurable convolution sequencer. Successor to the fixed-geometry conv control FSM.
- Walks filters → input channels → padded rows → padded columns. Emits weight-load strobes, IFM read/pad strobes, buffer addresses and window/output strobes for the PE array.
- IFM size, kernel, pad, stride, CI and CO are latched per job at start, not fixed by parameters. Adds stall and abort.

Parameters:
- MAX_IFM, 64, largest unpadded IFM side
- MAX_K, 7, largest kernel side
- MAX_PAD, 3, largest padding
- MAX_CI, 512, largest input-channel count
- MAX_CO, 512, largest filter count
- CW, $clog2(MAX_IFM+2*MAX_PAD+1), position counter width

Ports:
- clk1  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  job request, sampled only in IDLE
- abort  in  1  synchronous job cancel
- stall  in  1  downstream not ready; freezes sequencing
- cfg_ifm  in  CW  unpadded IFM side N
- cfg_k  in  $clog2(MAX_K+1)  kernel side K
- cfg_pad  in  $clog2(MAX_PAD+1)  padding P
- cfg_stride  in  3  stride S (1..4)
- cfg_ci  in  $clog2(MAX_CI+1)  channel count
- cfg_co  in  $clog2(MAX_CO+1)  filter count
- busy  out  1  job active
- done  out  1  one-cycle end-of-job pulse
- cfg_err  out  1  one-cycle pulse, start rejected
- wgt_read  out  1  weight fetch strobe
- wgt_idx  out  $clog2(MAX_K*MAX_K)  weight slot 0..K*K-1
- ifm_read  out  1  real pixel fetch at (addr_x,addr_y)
- pad_zero  out  1  current position is padding; PE uses 0
- addr_x, addr_y  out  CW  unpadded pixel coordinate (valid with ifm_read)
- addr_ci  out  $clog2(MAX_CI)  current channel
- addr_co  out  $clog2(MAX_CO)  current filter
- first_ch  out  1  current channel is 0 (accumulator clear)
- win_valid  out  1  window completes at current position
- out_valid  out  1  win_valid AND last channel
- out_x, out_y  out  CW  output coordinate, valid with win_valid

Behaviour:
- Reset (async, rst_n=0): state IDLE; all counters 0; every output 0.
- Derived values are latched at start: Pd = N+2P and O = (Pd−K)/S+1.
- States:
  - IDLE: on start, check config.
    - Error if K=0, S=0, S>4, N=0, CI=0, CO=0, or K>Pd. Then pulse cfg_err, stay IDLE.
    - Otherwise latch config, set busy, go to LOAD.
  - LOAD: K*K cycles, wgt_read=1, wgt_idx counts 0..K*K−1, then go to STREAM.
  - STREAM: one position per unstalled cycle, col 0..Pd−1 inner, row 0..Pd−1 outer. After the last position:
    - if ci<CI−1: ci++, go to LOAD;
    - else if co<CO−1: ci=0, co++, go to LOAD;
    - else go to FIN.
  - FIN: one cycle; done=1, busy=0, go to IDLE.
- STREAM decode (Moore, from registered counters):
  - pad_zero = row<P | row≥P+N | col<P | col≥P+N.
  - ifm_read = !pad_zero. addr_x = col−P, addr_y = row−P.
  - win_valid = row≥K−1, col≥K−1, (row−K+1)%S=0, (col−K+1)%S=0, and output index < O on both axes. Trailing positions that cannot fill a window are ignored.
  - out_x = (col−K+1)/S, out_y = (row−K+1)/S.
  - The %S and /S results come from incrementing phase and quotient counters, not dividers.
- Stall: when stall=1 in LOAD or STREAM:
  - counters and state hold;
  - wgt_read, ifm_read, pad_zero, win_valid and out_valid are forced 0;
  - addresses hold.
- Abort: in any busy state, next cycle goes to IDLE; counters cleared, busy=0, no done. Abort beats stall. Abort in IDLE is ignored.
- start is ignored while busy. Config inputs are don't-care after latch.
- Simultaneous start and abort in IDLE: start wins.
- first_ch is high during LOAD and STREAM of ci=0.
- Arithmetic is unsigned CW-bit; Pd and K*K use CW+1 bits internally.

Test Plan:
- N=5,K=3,P=1,S=1,CI=1,CO=1, start at cycle 0:
  - wgt_read cycles 1–9; STREAM cycles 10–58 (49 positions);
  - 25 ifm_read, 24 pad_zero, 25 win_valid/out_valid, out (0,0)..(4,4) raster;
  - done at cycle 59, busy low thereafter.
- N=9,K=4,P=2,S=2,CI=3,CO=4:
  - Pd=13, O=5; 12 LOAD bursts of 16;
  - 300 win_valid, 100 out_valid (only ci=2);
  - addr_co steps 0..3; a single done.
- Same config as the first case with stall=1 for 5 cycles mid-STREAM at position (3,2):
  - no strobes during stall; position (3,2) emitted after release;
  - totals unchanged; done delayed exactly 5 cycles.
- Abort asserted during the 2nd LOAD burst:
  - IDLE next cycle, busy=0, no done;
  - an immediate new start is accepted.
- Start with K=5,N=2,P=1 (K>Pd), and separately with S=0:
  - cfg_err pulse, busy stays 0, no strobes.
- rst_n low mid-STREAM, asynchronously:
  - all outputs 0 immediately; IDLE after release.
